// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - IF/DM arbiter for a single unified memory port
// One transaction outstanding; DM priority with a streak guard so fetch is not starved.
module mem_port_arbiter #(
    parameter int unsigned MAX_DM_STREAK = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_if_req,
    input  logic [31:0] i_if_addr,
    input  logic        i_if_flush,
    output logic        o_if_done,
    output logic [31:0] o_if_rdata,
    output logic        o_if_stall,
    input  logic        i_dm_req,
    input  logic        i_dm_we,
    input  logic [31:0] i_dm_addr,
    input  logic [31:0] i_dm_wdata,
    input  logic [3:0]  i_dm_be,
    output logic        o_dm_done,
    output logic [31:0] o_dm_rdata,
    output logic        o_dm_stall,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_be,
    input  logic        i_mem_ready,
    input  logic        i_mem_rvalid,
    input  logic [31:0] i_mem_rdata
);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT_R} state_t;

    localparam logic       OWNER_IF = 1'b0;
    localparam logic       OWNER_DM = 1'b1;
    localparam logic [3:0] LP_MAX   = 4'(MAX_DM_STREAK);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_owner;
    logic        r_discard;
    logic [3:0]  r_dm_streak;
    logic        r_mem_req;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [3:0]  r_mem_be;
    logic        r_if_done;
    logic        r_dm_done;
    logic [31:0] r_if_rdata;
    logic [31:0] r_dm_rdata;

    logic        w_if_elig;
    logic        w_dm_elig;
    logic        w_dm_win;
    logic        w_if_win;
    logic        w_if_flush_own;
    logic [3:0]  w_streak_inc;

    // A req seen during its own done cycle is the request just serviced.
    assign w_if_elig      = i_if_req & ~r_if_done & ~i_if_flush;
    assign w_dm_elig      = i_dm_req & ~r_dm_done;
    assign w_dm_win       = w_dm_elig & ((r_dm_streak < LP_MAX) | ~w_if_elig);
    assign w_if_win       = ~w_dm_win & w_if_elig;
    assign w_if_flush_own = i_if_flush & (r_owner == OWNER_IF);
    assign w_streak_inc   = (r_dm_streak == 4'hF) ? 4'hF : r_dm_streak + 4'd1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_dm_win || w_if_win) w_state_nxt = ST_REQ;
            ST_REQ:    if (i_mem_ready) w_state_nxt = r_mem_we ? ST_IDLE : ST_WAIT_R;
            ST_WAIT_R: if (i_mem_rvalid) w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_owner     <= OWNER_IF;
            r_discard   <= 1'b0;
            r_dm_streak <= 4'd0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
            r_mem_be    <= 4'd0;
            r_if_done   <= 1'b0;
            r_dm_done   <= 1'b0;
            r_if_rdata  <= 32'd0;
            r_dm_rdata  <= 32'd0;
        end else begin
            r_if_done <= 1'b0;
            r_dm_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_dm_win) begin
                        r_owner     <= OWNER_DM;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= i_dm_we;
                        r_mem_addr  <= i_dm_addr;
                        r_mem_wdata <= i_dm_wdata;
                        r_mem_be    <= i_dm_be;
                        r_discard   <= 1'b0;
                        r_dm_streak <= w_if_elig ? w_streak_inc : 4'd0;
                    end else if (w_if_win) begin
                        r_owner     <= OWNER_IF;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= i_if_addr;
                        r_mem_wdata <= 32'd0;
                        r_mem_be    <= 4'd0;
                        r_discard   <= 1'b0;
                        r_dm_streak <= 4'd0;
                    end
                end
                ST_REQ: begin
                    if (w_if_flush_own) r_discard <= 1'b1;
                    if (i_mem_ready) begin
                        r_mem_req <= 1'b0;
                        if (r_mem_we) r_dm_done <= 1'b1;
                    end
                end
                ST_WAIT_R: begin
                    if (w_if_flush_own) r_discard <= 1'b1;
                    // A flush arriving with the data still kills the fetch.
                    if (i_mem_rvalid) begin
                        if (r_owner == OWNER_DM) begin
                            r_dm_rdata <= i_mem_rdata;
                            r_dm_done  <= 1'b1;
                        end else if (!(r_discard || w_if_flush_own)) begin
                            r_if_rdata <= i_mem_rdata;
                            r_if_done  <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_if_done   = r_if_done;
    assign o_if_rdata  = r_if_rdata;
    assign o_if_stall  = i_if_req & ~r_if_done;
    assign o_dm_done   = r_dm_done;
    assign o_dm_rdata  = r_dm_rdata;
    assign o_dm_stall  = i_dm_req & ~r_dm_done;
    assign o_mem_req   = r_mem_req;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_mem_be    = r_mem_be;

endmodule
